// File: rtl/vx_commit_sender_pkg.sv
// Shared types for the commit sender: commit packet layout and field widths.
package vx_commit_sender_pkg;

  localparam int NUM_THREADS = 4;
  localparam int UUID_WIDTH  = 16;
  localparam int NW_WIDTH    = 4;
  localparam int NR_BITS     = 6;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]                uuid;
    logic [NW_WIDTH-1:0]                  wid;
    logic [NUM_THREADS-1:0]               tmask;
    logic [XLEN-1:0]                      PC;
    logic                                 wb;
    logic [NR_BITS-1:0]                   rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]     data;
    logic                                 sop;
    logic                                 eop;
  } commit_t;

endpackage

// File: rtl/vx_commit_sender_penc.sv
// Priority encoder: index of the lowest set request bit.
module vx_commit_sender_penc #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_commit_sender.sv
// Splits one instruction result into per-block commit packets, lowest active
// block first, with a registered output stage and no bubble between results.
module vx_commit_sender
  import vx_commit_sender_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int THREAD_CNT = NUM_THREADS,
  parameter int NUM_LANES  = THREAD_CNT
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    result_valid_i,
  input  commit_t result_data_i,
  output logic    result_ready_o,
  output logic    commit_valid_o,
  output commit_t commit_data_o,
  input  logic    commit_ready_i,
  output logic    busy_o
);

  localparam int NUM_BLOCKS = THREAD_CNT / NUM_LANES;
  localparam int BW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  if ((THREAD_CNT % NUM_LANES) != 0 || THREAD_CNT != NUM_THREADS || CORE_ID < 0) begin : g_bad_cfg
    $error("vx_commit_sender: NUM_LANES must divide THREAD_CNT");
  end

  state_e                state_q;
  logic                  valid_q;
  logic [NUM_BLOCKS-1:0] pend_q;
  commit_t               hold_q;
  commit_t               out_q;

  logic                  result_fire, commit_fire, eop_fire;
  logic [NUM_BLOCKS-1:0] blk_mask, sel_mask, pend_d;
  logic [BW-1:0]         sel_idx;
  logic                  sel_vld;
  commit_t               src, pkt_d;

  assign commit_fire    = valid_q && commit_ready_i;
  assign eop_fire       = commit_fire && out_q.eop;
  assign result_ready_o = (state_q == ST_IDLE) || eop_fire;
  assign result_fire    = result_valid_i && result_ready_o;
  assign commit_valid_o = valid_q;
  assign commit_data_o  = out_q;
  assign busy_o         = (state_q == ST_SEND);

  always_comb begin
    blk_mask = '0;
    for (int b = 0; b < NUM_BLOCKS; b++)
      blk_mask[b] = |result_data_i.tmask[b*NUM_LANES +: NUM_LANES];
  end

  // A fresh capture feeds the encoder directly so its first packet is
  // ready one cycle after the handshake.
  assign src      = result_fire ? result_data_i : hold_q;
  assign sel_mask = result_fire ? blk_mask : pend_q;

  vx_commit_sender_penc #(.N(NUM_BLOCKS)) u_penc (
    .req_i (sel_mask),
    .idx_o (sel_idx),
    .vld_o (sel_vld)
  );

  always_comb begin
    pend_d       = sel_mask & ~(NUM_BLOCKS'(1) << sel_idx);
    pkt_d        = src;
    pkt_d.tmask  = '0;
    pkt_d.data   = '0;
    for (int t = 0; t < THREAD_CNT; t++) begin
      if (sel_vld && (t / NUM_LANES) == int'(sel_idx)) begin
        pkt_d.tmask[t] = src.tmask[t];
        pkt_d.data[t]  = src.data[t];
      end
    end
    pkt_d.sop = result_fire;
    pkt_d.eop = (pend_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      pend_q  <= '0;
    end else if (result_fire) begin
      state_q <= ST_SEND;
      valid_q <= 1'b1;
      pend_q  <= pend_d;
    end else if (commit_fire) begin
      if (out_q.eop) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
      end else begin
        pend_q  <= pend_d;
      end
    end
  end

  // Payload registers carry no reset; valid_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (result_fire)
      hold_q <= result_data_i;
    if (result_fire || (commit_fire && !out_q.eop))
      out_q <= pkt_d;
  end

endmodule

// File: tb/tb_vx_commit_sender.sv
// Bench for vx_commit_sender: directed cases plus random traffic against a
// packet-list model, for one-lane and full-width configurations.
module tb_vx_commit_sender;
  import vx_commit_sender_pkg::*;

  logic    clk, rst;
  logic    r1v, r1r, c1v, c1r, b1;
  commit_t r1d, c1d;
  logic    r4v, r4r, c4v, c4r, b4;
  commit_t r4d, c4d;

  int      cmp_cnt = 0;
  int      mis_cnt = 0;
  commit_t q1[$];
  commit_t q4[$];
  logic    stall_p[2];
  commit_t stall_d[2];
  logic    acc1;

  vx_commit_sender #(.CORE_ID(0), .THREAD_CNT(4), .NUM_LANES(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .result_valid_i(r1v), .result_data_i(r1d),
    .result_ready_o(r1r), .commit_valid_o(c1v), .commit_data_o(c1d),
    .commit_ready_i(c1r), .busy_o(b1));

  vx_commit_sender #(.CORE_ID(1), .THREAD_CNT(4), .NUM_LANES(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .result_valid_i(r4v), .result_data_i(r4d),
    .result_ready_o(r4r), .commit_valid_o(c4v), .commit_data_o(c4d),
    .commit_ready_i(c4r), .busy_o(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic commit_t rnd_commit(input logic [3:0] tm);
    commit_t c;
    c.uuid  = UUID_WIDTH'($urandom);
    c.wid   = NW_WIDTH'($urandom);
    c.tmask = tm;
    c.PC    = $urandom;
    c.wb    = 1'($urandom);
    c.rd    = NR_BITS'($urandom);
    for (int i = 0; i < 4; i++) c.data[i] = $urandom;
    c.sop   = 1'($urandom);
    c.eop   = 1'($urandom);
    return c;
  endfunction

  // Expected packets: one per block that has any active thread, ascending;
  // an empty mask still yields a single all-zero packet.
  function automatic void add_exp(input commit_t c, input int nl, input int sel);
    int nb = 4 / nl;
    int total = 0;
    int cnt = 0;
    logic [3:0] act = '0;
    commit_t p;
    for (int t = 0; t < 4; t++) if (c.tmask[t]) act[t / nl] = 1'b1;
    for (int b = 0; b < nb; b++) if (act[b]) total++;
    if (total == 0) begin
      p = c; p.tmask = '0; p.data = '0; p.sop = 1'b1; p.eop = 1'b1;
      if (sel == 1) q1.push_back(p); else q4.push_back(p);
    end else begin
      for (int b = 0; b < nb; b++) begin
        if (act[b]) begin
          p = c; p.tmask = '0; p.data = '0;
          for (int t = 0; t < 4; t++) if (t / nl == b) begin
            p.tmask[t] = c.tmask[t];
            p.data[t]  = c.data[t];
          end
          p.sop = (cnt == 0);
          p.eop = (cnt == total - 1);
          cnt++;
          if (sel == 1) q1.push_back(p); else q4.push_back(p);
        end
      end
    end
  endfunction

  task automatic sb(input int sel, input logic cv, input logic cr, input commit_t cd,
                    input logic rv, input logic rr, input commit_t rd);
    commit_t e;
    int k = (sel == 1) ? 0 : 1;
    if (sel == 1) acc1 = 1'b0;
    if (rst) begin
      if (sel == 1) q1.delete(); else q4.delete();
      stall_p[k] = 1'b0;
      return;
    end
    if (stall_p[k]) chk(sel == 1 ? "stall_hold1" : "stall_hold4", {cv, cd}, {1'b1, stall_d[k]});
    stall_p[k] = cv && !cr;
    stall_d[k] = cd;
    if (cv && cr) begin
      if (sel == 1) begin
        if (q1.size() == 0) chk("spurious_pkt1", 1, 0);
        else begin e = q1.pop_front(); chk("pkt1", cd, e); end
      end else begin
        if (q4.size() == 0) chk("spurious_pkt4", 1, 0);
        else begin e = q4.pop_front(); chk("pkt4", cd, e); end
      end
    end
    if (rv && rr) begin
      add_exp(rd, sel == 1 ? 1 : 4, sel);
      if (sel == 1) acc1 = 1'b1;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sb(1, c1v, c1r, c1d, r1v, r1r, r1d);
    sb(4, c4v, c4r, c4d, r4v, r4r, r4d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    commit_t a, b;
    int nacc;
    stall_p[0] = 1'b0; stall_p[1] = 1'b0; acc1 = 1'b0;
    rst = 1'b1;
    r1v = 1'b0; r1d = rnd_commit(4'h0); c1r = 1'b1;
    r4v = 1'b0; r4d = rnd_commit(4'h0); c4r = 1'b1;
    cyc(); cyc();
    chk("rst_valid", c1v, 0);
    chk("rst_busy", b1, 0);
    chk("rst_ready", r1r, 1);
    rst = 1'b0;
    cyc();

    // Full mask: four packets on consecutive cycles.
    r1d = rnd_commit(4'b1111); r1v = 1'b1; #1;
    chk("full_ready", r1r, 1);
    cyc(); r1v = 1'b0;
    chk("full_lat_valid", c1v, 1);
    chk("full_p0_tmask", c1d.tmask, 4'b0001);
    chk("full_p0_sop", {c1d.sop, c1d.eop}, 2'b10);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("full_pk_valid", c1v, 1);
      chk("full_pk_tmask", c1d.tmask, 4'b0001 << k);
    end
    chk("full_last_eop", {c1d.sop, c1d.eop}, 2'b01);
    cyc();
    chk("full_idle_valid", c1v, 0);
    chk("full_idle_busy", b1, 0);

    // Sparse mask: blocks 1 and 3 only.
    r1d = rnd_commit(4'b1010); r1v = 1'b1;
    cyc(); r1v = 1'b0;
    chk("sparse_p0", {c1d.tmask, c1d.sop, c1d.eop}, {4'b0010, 2'b10});
    chk("sparse_p0_zero", {c1d.data[0], c1d.data[2], c1d.data[3]}, 96'h0);
    cyc();
    chk("sparse_p1", {c1d.tmask, c1d.sop, c1d.eop}, {4'b1000, 2'b01});
    chk("sparse_p1_data", c1d.data[3], r1d.data[3]);
    cyc();
    chk("sparse_idle", c1v, 0);

    // Empty mask: single zero packet.
    r1d = rnd_commit(4'b0000); r1v = 1'b1;
    cyc(); r1v = 1'b0;
    chk("empty_pkt", {c1v, c1d.tmask, c1d.data, c1d.sop, c1d.eop}, {1'b1, 4'b0, 128'h0, 2'b11});
    chk("empty_busy", b1, 1);
    cyc();
    chk("empty_busy_after", b1, 0);

    // Back-to-back results under a toggling ready.
    a = rnd_commit(4'b0110); b = rnd_commit(4'b1011);
    r1d = a; r1v = 1'b1; nacc = 0;
    for (int k = 0; k < 20; k++) begin
      c1r = (k % 2 == 0); #1;
      if (r1v && r1r && nacc == 1) chk("b2b_on_eop", c1v && c1r && c1d.eop, 1);
      cyc();
      if (acc1) begin
        nacc++;
        if (nacc == 1) r1d = b; else r1v = 1'b0;
      end
    end
    c1r = 1'b1;
    chk("b2b_accepts", nacc, 2);
    chk("b2b_drained", q1.size(), 0);

    // Reset with the second of four packets pending.
    r1d = rnd_commit(4'b1111); r1v = 1'b1;
    cyc(); r1v = 1'b0;
    cyc(); c1r = 1'b0;
    chk("rst_mid_busy", b1, 1);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("rst_mid_valid", c1v, 0);
    chk("rst_mid_busy0", b1, 0);
    chk("rst_mid_ready", r1r, 1);
    c1r = 1'b1;
    cyc();
    chk("rst_mid_nopkt", c1v, 0);

    // Random traffic on the one-lane instance.
    r1v = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (acc1 || !r1v) begin
        r1v = ($urandom_range(0, 3) != 0);
        r1d = rnd_commit(4'($urandom));
      end
      c1r = ($urandom_range(0, 3) != 0);
      cyc();
    end
    r1v = 1'b0; c1r = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (!b1 && !c1v) break;
      cyc();
    end
    chk("rand_drain_busy", b1, 0);
    chk("rand_drain_queue", q1.size(), 0);

    // Full-width instance: one packet per instruction, one per cycle.
    for (int k = 0; k < 50; k++) begin
      r4d = rnd_commit(4'($urandom)); r4v = 1'b1; c4r = 1'b1; #1;
      chk("l4_ready", r4r, 1);
      if (k > 0) chk("l4_valid", c4v, 1);
      cyc();
    end
    r4v = 1'b0;
    cyc(); cyc();
    chk("l4_idle", c4v, 0);
    chk("l4_drained", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/vx_commit_sender.md
VX_COMMIT_SENDER -- requirements
Module: VX_commit_sender

Interface
REQ-001 Parameter CORE_ID, default 0, core index used in trace messages only.
REQ-002 Parameter THREAD_CNT, default `NUM_THREADS, thread count of one commit packet.
REQ-003 Parameter NUM_LANES, default THREAD_CNT, execute lanes per packet; SHALL divide THREAD_CNT evenly.
REQ-004 Local constant NUM_BLOCKS = THREAD_CNT / NUM_LANES.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 result_if  VX_commit_if.slave  commit_t  one whole instruction result per handshake; result_if.data.sop and result_if.data.eop are ignored.
REQ-008 commit_if  VX_commit_if.master  commit_t  per-block commit packets sent to the core commit stage.
REQ-009 busy  output  1  high while a captured instruction still has packets left to send.

Function
REQ-010 Each result handshake (valid && ready) SHALL capture the whole result into a holding register and mark all blocks whose tmask slice [b*NUM_LANES +: NUM_LANES] is non-zero as pending.
REQ-011 Block b of a packet SHALL carry tmask bits and data lanes of block b only; all other tmask bits and data lanes SHALL be zero.
REQ-012 uuid, wid, PC, wb and rd SHALL be copied unchanged into every packet of the instruction.
REQ-013 Pending blocks SHALL be sent in ascending block index, selected by a priority encoder; inactive blocks are skipped.
REQ-014 sop SHALL be 1 on the first packet of an instruction only; eop SHALL be 1 on the last packet only; a single-packet instruction has sop=eop=1.
REQ-015 If the tmask is all zero, exactly one packet SHALL be sent: block 0, tmask=0, data=0, sop=eop=1.
REQ-016 State machine: IDLE (no holding data) -> SEND on result fire; SEND -> IDLE on the eop packet fire with no new result fire; SEND -> SEND on an eop packet fire in the same cycle as a new result fire.
REQ-017 result_if.ready = (state==IDLE) || (commit_if.valid && commit_if.ready && commit_if.data.eop), giving back-to-back instructions with no bubble.
REQ-018 Latency: a result fire in cycle t SHALL make the first packet valid in cycle t+1; with ready held high, one packet SHALL be sent per cycle.
REQ-019 commit_if.valid SHALL be driven from a register; while valid && !ready, all commit_if.data fields SHALL stay stable.
REQ-020 A packet fire SHALL clear its block from the pending mask; the eop fire and a new capture in the same cycle SHALL load the new mask, and the new capture takes precedence.
REQ-021 busy = (state==SEND).
REQ-022 With NUM_LANES==THREAD_CNT, every instruction SHALL produce exactly one packet with sop=eop=1 and full tmask/data passthrough.
REQ-023 Under DBG_TRACE_CORE_PIPELINE, each packet fire SHALL print wid, PC, tmask, sop, eop and uuid.

Reset
REQ-024 On reset, the block SHALL go to IDLE, clear the pending mask and drive commit_if.valid=0 and busy=0; result_if.ready SHALL be 1 in the first cycle after reset.
REQ-025 Reset during SEND SHALL drop the captured instruction without sending any further packets.
REQ-026 The data-path registers (holding payload and output data) need no reset.

Structure
REQ-027 commit_t and its field widths (`UUID_WIDTH, `NW_WIDTH, `NR_BITS, `XLEN) SHALL come from VX_gpu_pkg; NUM_BLOCKS and the state encoding are local to the module.
REQ-028 Next-block selection SHALL use the existing VX_priority_encoder sub-module over the NUM_BLOCKS-bit pending mask.

Verification (THREAD_CNT=4, NUM_LANES=1 unless stated)
REQ-029 tmask=4'b1111, data={D3,D2,D1,D0}, ready=1 -> 4 packets on consecutive cycles, tmask 0001/0010/0100/1000, sop only on the first, eop only on the last.
REQ-030 tmask=4'b1010 -> 2 packets, tmask 0010 (sop=1, eop=0) then 1000 (sop=0, eop=1); inactive lanes carry zero data.
REQ-031 tmask=4'b0000 -> 1 packet, block 0, tmask=0, sop=eop=1; busy returns to 0 the next cycle.
REQ-032 Two results back-to-back, commit_if.ready toggling 1,0,1,0 -> packet fields stable while stalled; the second result is accepted on the eop fire cycle; no packet is lost or duplicated.
REQ-033 Reset asserted while the second of 4 packets is pending -> commit_if.valid=0 and busy=0 the next cycle; result_if.ready=1.
REQ-034 NUM_LANES=4, random tmask -> 1 packet per instruction with sop=eop=1 and full passthrough at 1 instruction per cycle.
